// File: rtl/circuito_pwm_multicanal_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Servo timing assumes a 50 MHz clock and a 20 ms frame.
package circuito_pwm_multicanal_pkg;

  localparam int unsigned PERIODO_SERVO_50MHZ = 1_000_000;
  localparam int unsigned LARGURA_0_GRAUS     = 50_000;
  localparam int unsigned LARGURA_90_GRAUS    = 75_000;
  localparam int unsigned LARGURA_180_GRAUS   = 100_000;

  localparam int unsigned N_CANAIS_PADRAO     = 4;
  localparam int unsigned LARGURA_BITS_PADRAO = 20;
  localparam int unsigned CANAL_BITS_PADRAO   = 2;

  // Widths above the period would behave like the period anyway; clamping keeps the stored value meaningful.
  function automatic logic [31:0] satura(input logic [31:0] valor, input logic [31:0] limite);
    return (valor > limite) ? limite : valor;
  endfunction

endpackage

// File: rtl/circuito_pwm_multicanal_canal.sv
// One PWM channel: double-buffered width, deferred enable and registered output.
// The output is computed from the next counter value so it lines up with the counter register.
module pwm_canal
  import circuito_pwm_multicanal_pkg::*;
#(
  parameter int CONF_PERIODO = 1_000_000,
  parameter int LARGURA_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    escreve_i,
  input  logic [LARGURA_BITS-1:0] largura_i,
  input  logic                    fim_i,
  input  logic [LARGURA_BITS-1:0] contador_prox_i,
  input  logic                    habilita_i,
  output logic                    pwm_o
);

  logic [LARGURA_BITS-1:0] largura_sat;
  logic [LARGURA_BITS-1:0] pendente_q, pendente_d;
  logic [LARGURA_BITS-1:0] ativo_q, ativo_d;
  logic                    hab_ativo_q, hab_ativo_d;
  logic                    pwm_q, pwm_d;

  assign largura_sat = LARGURA_BITS'(satura(32'(largura_i), 32'(CONF_PERIODO)));

  // A write on the boundary edge goes straight into the active width as well.
  always_comb begin
    pendente_d  = escreve_i ? largura_sat : pendente_q;
    ativo_d     = ativo_q;
    hab_ativo_d = hab_ativo_q;
    if (fim_i) begin
      ativo_d = pendente_d;
    end
    if (!habilita_i) begin
      hab_ativo_d = 1'b0;
    end else if (fim_i) begin
      hab_ativo_d = 1'b1;
    end
    pwm_d = (contador_prox_i < ativo_d) && hab_ativo_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pendente_q  <= '0;
      ativo_q     <= '0;
      hab_ativo_q <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      pendente_q  <= pendente_d;
      ativo_q     <= ativo_d;
      hab_ativo_q <= hab_ativo_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/circuito_pwm_multicanal.sv
// Multi-channel edge-aligned PWM generator sharing one period counter.
// Widths are written per channel and take effect at the next period boundary.
module circuito_pwm_multicanal
  import circuito_pwm_multicanal_pkg::*;
#(
  parameter int CONF_PERIODO = PERIODO_SERVO_50MHZ,
  parameter int N_CANAIS     = N_CANAIS_PADRAO,
  parameter int LARGURA_BITS = LARGURA_BITS_PADRAO,
  parameter int CANAL_BITS   = CANAL_BITS_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    escreve,
  input  logic [CANAL_BITS-1:0]   canal,
  input  logic [LARGURA_BITS-1:0] largura,
  input  logic [N_CANAIS-1:0]     habilita,
  output logic [N_CANAIS-1:0]     pwm,
  output logic                    fim_periodo
);

  localparam logic [LARGURA_BITS-1:0] ULTIMA_CONTAGEM = LARGURA_BITS'(CONF_PERIODO - 1);

  logic [LARGURA_BITS-1:0] contador_q, contador_d;
  logic                    fim_q, fim_d;

  // fim_q is kept equal to (contador_q == last count) by registering the same test on the next value.
  always_comb begin
    contador_d = (contador_q == ULTIMA_CONTAGEM) ? '0 : contador_q + LARGURA_BITS'(1);
    fim_d      = (contador_d == ULTIMA_CONTAGEM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contador_q <= '0;
      fim_q      <= 1'b0;
    end else begin
      contador_q <= contador_d;
      fim_q      <= fim_d;
    end
  end

  assign fim_periodo = fim_q;

  // Out-of-range channel indices match no instance, so such writes are dropped.
  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    logic escreve_canal;
    assign escreve_canal = escreve && (canal == CANAL_BITS'(i));

    pwm_canal #(
      .CONF_PERIODO (CONF_PERIODO),
      .LARGURA_BITS (LARGURA_BITS)
    ) u_canal (
      .clock           (clock),
      .reset           (reset),
      .escreve_i       (escreve_canal),
      .largura_i       (largura),
      .fim_i           (fim_q),
      .contador_prox_i (contador_d),
      .habilita_i      (habilita[i]),
      .pwm_o           (pwm[i])
    );
  end

endmodule

// File: tb/tb_circuito_pwm_multicanal.sv
// Self-checking bench: directed scenarios plus random writes/enables/resets
// compared cycle by cycle against a period-level behavioural model.
module tb_circuito_pwm_multicanal;

  localparam int P  = 1250;
  localparam int N  = 3;
  localparam int LB = 11;
  localparam int CB = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          escreve;
  logic [CB-1:0] canal;
  logic [LB-1:0] largura;
  logic [N-1:0]  habilita;
  logic [N-1:0]  pwm;
  logic          fim_periodo;

  always #5 clock = ~clock;

  circuito_pwm_multicanal #(
    .CONF_PERIODO (P),
    .N_CANAIS     (N),
    .LARGURA_BITS (LB),
    .CANAL_BITS   (CB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .escreve     (escreve),
    .canal       (canal),
    .largura     (largura),
    .habilita    (habilita),
    .pwm         (pwm),
    .fim_periodo (fim_periodo)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position in the period, requested and active widths, armed enables.
  int           mCnt;
  int           mPend [N];
  int           mAct  [N];
  bit           mHab  [N];
  logic [N-1:0] expPwm;
  logic         expFim;
  logic [N-1:0] habReg;
  int           hiCnt [N];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit rst, input bit wr, input int c, input int l, input logic [N-1:0] h);
    bit boundary;
    if (rst) begin
      mCnt = 0;
      for (int i = 0; i < N; i++) begin
        mPend[i] = 0;
        mAct[i]  = 0;
        mHab[i]  = 0;
      end
      expPwm = '0;
      expFim = 1'b0;
      return;
    end
    boundary = (mCnt == P - 1);
    if (wr && c < N) mPend[c] = (l > P) ? P : l;
    for (int i = 0; i < N; i++) begin
      if (boundary) mAct[i] = mPend[i];
      if (!h[i]) mHab[i] = 0;
      else if (boundary) mHab[i] = 1;
    end
    mCnt = (mCnt + 1) % P;
    for (int i = 0; i < N; i++) expPwm[i] = (mCnt < mAct[i]) && mHab[i];
    expFim = (mCnt == P - 1);
  endtask

  task automatic applyStimulus(input bit rst, input bit wr, input int c, input int l, input logic [N-1:0] h);
    logic [31:0] cv, lv;
    cv = c;
    lv = l;
    reset    = rst;
    escreve  = wr;
    canal    = cv[CB-1:0];
    largura  = lv[LB-1:0];
    habilita = h;
    modelStep(rst, wr, c, l, h);
    @(posedge clock);
    #1;
    checkOutput("pwm", {29'd0, pwm}, {29'd0, expPwm});
    checkOutput("fim_periodo", {31'd0, fim_periodo}, {31'd0, expFim});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, habReg);
  endtask

  task automatic idleUntil(input int cnt);
    for (int k = 0; k < 2 * P; k++) begin
      if (mCnt == cnt) break;
      idle(1);
    end
  endtask

  task automatic writeWidth(input int c, input int l);
    applyStimulus(0, 1, c, l, habReg);
  endtask

  // Aligns to the end of a period, then counts high cycles of each channel over one full period.
  task automatic sumPeriod();
    idleUntil(P - 1);
    for (int i = 0; i < N; i++) hiCnt[i] = 0;
    repeat (P) begin
      idle(1);
      for (int i = 0; i < N; i++) hiCnt[i] += int'(pwm[i]);
    end
  endtask

  initial begin
    int fimCycles;
    reset = 1'b1; escreve = 1'b0; canal = '0; largura = '0; habilita = '0;
    habReg = '0;
    applyStimulus(1, 0, 0, 0, habReg);
    applyStimulus(1, 0, 0, 0, habReg);

    // First end-of-period pulse must come a full period after release.
    fimCycles = 0;
    for (int k = 0; k < 2 * P; k++) begin
      idle(1);
      fimCycles++;
      if (fim_periodo === 1'b1) break;
    end
    checkOutput("first_fim_delay", fimCycles, P - 1);

    // Mid-run reset then deferred update of channel 0.
    idleUntil(400);
    applyStimulus(1, 0, 0, 0, habReg);
    habReg = 3'b111;
    idleUntil(300);
    writeWidth(0, 50);
    sumPeriod();
    checkOutput("deferred_width_ch0", hiCnt[0], 50);

    // Extremes and saturation.
    writeWidth(1, 0);
    writeWidth(2, 1250);
    sumPeriod();
    checkOutput("zero_width_ch1", hiCnt[1], 0);
    checkOutput("full_width_ch2", hiCnt[2], P);
    writeWidth(2, 2000);
    sumPeriod();
    checkOutput("saturated_ch2", hiCnt[2], P);
    checkOutput("ch0_kept", hiCnt[0], 50);

    // Write-through on the boundary edge.
    idleUntil(P - 1);
    writeWidth(0, 500);
    hiCnt[0] = int'(pwm[0]);
    repeat (P - 1) begin
      idle(1);
      hiCnt[0] += int'(pwm[0]);
    end
    checkOutput("write_through_ch0", hiCnt[0], 500);
    writeWidth(0, 50);
    idleUntil(P - 1);
    idle(1);

    // Enable drop truncates, raise waits for the boundary.
    idleUntil(20);
    habReg = 3'b110;
    idle(1);
    checkOutput("enable_drop_ch0", {31'd0, pwm[0]}, 32'd0);
    idleUntil(600);
    habReg = 3'b111;
    idle(1);
    checkOutput("enable_raise_waits", {31'd0, pwm[0]}, 32'd0);
    sumPeriod();
    checkOutput("enable_full_pulse", hiCnt[0], 50);

    // Out-of-range channel write is ignored.
    writeWidth(3, 700);
    sumPeriod();
    checkOutput("oor_ch0", hiCnt[0], 50);
    checkOutput("oor_ch1", hiCnt[1], 0);
    checkOutput("oor_ch2", hiCnt[2], P);

    // Random traffic against the model.
    for (int k = 0; k < 8000; k++) begin
      bit rstR, wrR;
      rstR = ($urandom_range(0, 2999) == 0);
      wrR  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 299) == 0) habReg[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 1) == 0 && wrR)
        applyStimulus(rstR, wrR, $urandom_range(0, 3), (mCnt * 7) % 2048, habReg);
      else
        applyStimulus(rstR, wrR, $urandom_range(0, 3), $urandom_range(0, 2047), habReg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
